// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the streaming binary-to-BCD converter: FSM encoding
// and a constant helper sizing the decimal digit count for a binary width.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Decimal digits needed to show 2^bin_w - 1; this also covers the signed
    // case, whose largest magnitude is 2^(bin_w-1).
    function automatic int bcd_digits_for(input int bin_w);
        longint unsigned max_val;
        int              n;
        max_val = (64'd1 << bin_w) - 64'd1;
        n       = 1;
        while (max_val >= 64'd10) begin
            max_val = max_val / 64'd10;
            n       = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: values of 5 or more get +3 so
// that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= 4'd5) begin
            digit_out = digit_in + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_stream.sv
// Valid/ready streaming binary-to-BCD converter; one double-dabble step per
// cycle, with optional two's-complement input and a sticky overflow flag.
module bin2bcd_stream
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W     = 12,
    parameter int DIGITS    = 4,
    parameter int SIGNED_EN = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_neg,
    output logic                  out_ovf
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    // When the digit count can hold every input, overflow is structurally 0.
    localparam bit OVF_POSSIBLE = (DIGITS < bcd_digits_for(BIN_W));
    localparam logic [BIN_W-1:0] ONE_BIN = BIN_W'(1);

    generate
        if ((BIN_W < 4) || (BIN_W > 32)) begin : g_bad_bin_w
            $error("bin2bcd_stream: BIN_W=%0d outside 4..32", BIN_W);
        end
        if ((DIGITS < 1) || (DIGITS > 10)) begin : g_bad_digits
            $error("bin2bcd_stream: DIGITS=%0d outside 1..10", DIGITS);
        end
        if ((SIGNED_EN < 0) || (SIGNED_EN > 1)) begin : g_bad_signed
            $error("bin2bcd_stream: SIGNED_EN=%0d must be 0 or 1", SIGNED_EN);
        end
    endgenerate

    state_t                 state_reg, state_next;
    logic [BCD_W-1:0]       bcd_reg,   bcd_next;
    logic [BIN_W-1:0]       bin_reg,   bin_next;
    logic [CNT_W-1:0]       cnt_reg,   cnt_next;
    logic                   neg_reg,   neg_next;
    logic                   ovf_reg,   ovf_next;

    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+BIN_W:0]   shifted;
    logic                   accept;
    logic                   in_is_neg;
    logic [BIN_W-1:0]       in_mag;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_adj u_adj (
                .digit_in  (bcd_reg[4*gi +: 4]),
                .digit_out (bcd_adj[4*gi +: 4])
            );
        end
    endgenerate

    // Adjusted digits and the binary word form one register shifted as a unit;
    // the top bit is what falls out of the most significant digit.
    assign shifted = {bcd_adj, bin_reg, 1'b0};

    assign in_ready = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Most negative input negates to itself, which read unsigned is 2^(BIN_W-1).
    assign in_is_neg = (SIGNED_EN != 0) && in_data[BIN_W-1];
    assign in_mag    = in_is_neg ? (~in_data + ONE_BIN) : in_data;

    always_comb begin
        state_next = state_reg;
        bcd_next   = bcd_reg;
        bin_next   = bin_reg;
        cnt_next   = cnt_reg;
        neg_next   = neg_reg;
        ovf_next   = ovf_reg;

        case (state_reg)
            IDLE: begin
                state_next = IDLE;
            end
            CONV: begin
                bcd_next = shifted[BCD_W+BIN_W-1 -: BCD_W];
                bin_next = shifted[BIN_W-1:0];
                ovf_next = ovf_reg | (OVF_POSSIBLE & shifted[BCD_W+BIN_W]);
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Accept overrides both the IDLE hold and the DONE drain.
        if (accept) begin
            state_next = CONV;
            bcd_next   = '0;
            bin_next   = in_mag;
            cnt_next   = CNT_W'(BIN_W);
            neg_next   = in_is_neg;
            ovf_next   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            bcd_reg   <= '0;
            bin_reg   <= '0;
            cnt_reg   <= '0;
            neg_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            bcd_reg   <= bcd_next;
            bin_reg   <= bin_next;
            cnt_reg   <= cnt_next;
            neg_reg   <= neg_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign out_valid = (state_reg == DONE);
    assign out_bcd   = bcd_reg;
    assign out_neg   = neg_reg;
    assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_bin2bcd_stream.sv
// Randomized and directed bench for bin2bcd_stream across three configurations,
// checked against an arithmetic decimal-conversion model.
module tb_bin2bcd_stream;

    localparam int BW = 12;

    logic        clk;
    logic        reset_n;
    logic        in_valid_a  [3];
    logic        in_ready_a  [3];
    logic [11:0] in_data_a   [3];
    logic        out_valid_a [3];
    logic        out_ready_a [3];
    logic [15:0] out_bcd_a   [3];
    logic        out_neg_a   [3];
    logic        out_ovf_a   [3];
    logic [11:0] out_bcd_d3;

    int checks = 0;
    int errors = 0;

    // 0: defaults, 1: signed input, 2: three digits
    bin2bcd_stream u_dut_def (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .in_data(in_data_a[0]),
        .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .out_bcd(out_bcd_a[0]),
        .out_neg(out_neg_a[0]), .out_ovf(out_ovf_a[0])
    );

    bin2bcd_stream #(.BIN_W(12), .DIGITS(4), .SIGNED_EN(1)) u_dut_sgn (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .in_data(in_data_a[1]),
        .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .out_bcd(out_bcd_a[1]),
        .out_neg(out_neg_a[1]), .out_ovf(out_ovf_a[1])
    );

    bin2bcd_stream #(.BIN_W(12), .DIGITS(3), .SIGNED_EN(0)) u_dut_d3 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]), .in_data(in_data_a[2]),
        .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]), .out_bcd(out_bcd_d3),
        .out_neg(out_neg_a[2]), .out_ovf(out_ovf_a[2])
    );

    assign out_bcd_a[2] = {4'h0, out_bcd_d3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Decimal reference: magnitude by plain arithmetic, digits by repeated /10.
    function automatic void ref_model(input int idx, input logic [11:0] d,
                                      output logic [15:0] bcd, output logic neg,
                                      output logic ovf);
        int mag, lim, v, ndig, acc;
        ndig = (idx == 2) ? 3 : 4;
        mag  = int'(d);
        neg  = 1'b0;
        if (idx == 1 && d[11]) begin
            mag = 4096 - int'(d);
            neg = 1'b1;
        end
        lim = 1;
        for (int i = 0; i < ndig; i++) lim = lim * 10;
        ovf = (mag >= lim);
        v   = mag % lim;
        acc = 0;
        for (int i = 0; i < ndig; i++) begin
            acc = acc | ((v % 10) << (4 * i));
            v   = v / 10;
        end
        bcd = 16'(acc);
    endfunction

    // Entered and left just after a rising edge; result is left in DONE.
    task automatic send(input int idx, input logic [11:0] d, input bit from_done,
                        input bit noise, output logic [15:0] exp_bcd);
        logic exp_neg, exp_ovf;
        int   w;
        ref_model(idx, d, exp_bcd, exp_neg, exp_ovf);
        in_valid_a[idx] = 1'b1;
        in_data_a[idx]  = d;
        if (from_done) out_ready_a[idx] = 1'b1;
        #1;
        if (from_done) check("no_bubble_valid", 64'(out_valid_a[idx]), 64'(1));
        w = 0;
        while (!in_ready_a[idx] && w < 20) begin
            @(posedge clk); #2;
            w++;
        end
        check("accept_ready", 64'(in_ready_a[idx]), 64'(1));
        @(posedge clk); #1;
        in_valid_a[idx]  = 1'b0;
        out_ready_a[idx] = 1'b0;
        for (int k = 1; k <= BW; k++) begin
            if (noise && k <= 10) begin
                in_valid_a[idx] = k[0];
                in_data_a[idx]  = 12'((k + 1) / 2);
            end else begin
                in_valid_a[idx] = 1'b0;
            end
            #1;
            if (noise) check("conv_in_ready", 64'(in_ready_a[idx]), 64'(0));
            @(posedge clk); #1;
            if (k == 1)      check("conv_valid_early", 64'(out_valid_a[idx]), 64'(0));
            if (k == BW - 1) check("conv_valid_late", 64'(out_valid_a[idx]), 64'(0));
        end
        in_valid_a[idx] = 1'b0;
        check("valid_at_latency", 64'(out_valid_a[idx]), 64'(1));
        check("bcd", 64'(out_bcd_a[idx]), 64'(exp_bcd));
        check("neg", 64'(out_neg_a[idx]), 64'(exp_neg));
        check("ovf", 64'(out_ovf_a[idx]), 64'(exp_ovf));
        $display("xfer dut%0d in=%03h bcd=%04h neg=%0d ovf=%0d exp_bcd=%04h",
                 idx, d, out_bcd_a[idx], out_neg_a[idx], out_ovf_a[idx], exp_bcd);
    endtask

    task automatic drain(input int idx);
        out_ready_a[idx] = 1'b1;
        @(posedge clk); #1;
        out_ready_a[idx] = 1'b0;
        check("drain_idle", 64'(out_valid_a[idx]), 64'(0));
    endtask

    initial begin
        logic [15:0] eb, hold_bcd;
        logic        hold_neg, hold_ovf, seen;
        for (int i = 0; i < 3; i++) begin
            in_valid_a[i]  = 1'b0;
            in_data_a[i]   = '0;
            out_ready_a[i] = 1'b0;
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_valid", 64'(out_valid_a[i]), 64'(0));
            check("rst_bcd", 64'(out_bcd_a[i]), 64'(0));
            check("rst_ready", 64'(in_ready_a[i]), 64'(1));
            check("rst_ovf_neg", 64'({out_ovf_a[i], out_neg_a[i]}), 64'(0));
        end

        // Directed corner values per configuration
        send(0, 12'd4095, 0, 0, eb); drain(0);
        send(0, 12'd0,    0, 0, eb); drain(0);
        send(1, 12'h800,  0, 0, eb); drain(1);
        send(1, 12'hFFF,  0, 0, eb); drain(1);
        send(1, 12'h7FF,  0, 0, eb); drain(1);
        send(2, 12'd1234, 0, 0, eb); drain(2);
        send(2, 12'd999,  0, 0, eb); drain(2);
        send(2, 12'd1000, 0, 0, eb); drain(2);

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 3; i++) begin
                send(i, 12'($urandom_range(0, 4095)), 0, 0, eb);
                drain(i);
            end
        end

        // Stall in DONE, then back-to-back accept on the draining edge
        send(0, 12'd3581, 0, 0, eb);
        hold_bcd = out_bcd_a[0];
        hold_neg = out_neg_a[0];
        hold_ovf = out_ovf_a[0];
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("stall_valid", 64'(out_valid_a[0]), 64'(1));
            check("stall_bcd", 64'(out_bcd_a[0]), 64'(eb));
            check("stall_flags", 64'({out_neg_a[0], out_ovf_a[0]}), 64'({hold_neg, hold_ovf}));
            check("stall_ready", 64'(in_ready_a[0]), 64'(0));
        end
        check("stall_hold", 64'(out_bcd_a[0]), 64'(hold_bcd));
        send(0, 12'd7, 1, 0, eb);
        check("b2b_value", 64'(eb), 64'(16'h0007));
        drain(0);

        // Input noise during CONV must be ignored
        send(0, 12'd2222, 0, 1, eb);
        drain(0);
        seen = 1'b0;
        repeat (16) begin
            @(posedge clk); #1;
            seen = seen | out_valid_a[0];
        end
        check("noise_no_extra", 64'(seen), 64'(0));

        // Reset sampled on the 6th CONV edge
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = 12'h5A5;
        #1;
        check("rstconv_ready", 64'(in_ready_a[0]), 64'(1));
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("rstconv_valid", 64'(out_valid_a[0]), 64'(0));
        check("rstconv_bcd", 64'(out_bcd_a[0]), 64'(0));
        check("rstconv_flags", 64'({out_neg_a[0], out_ovf_a[0]}), 64'(0));
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rstconv_ready_after", 64'(in_ready_a[0]), 64'(1));
        seen = 1'b0;
        repeat (14) begin
            @(posedge clk); #1;
            seen = seen | out_valid_a[0];
        end
        check("rstconv_no_result", 64'(seen), 64'(0));
        check("rstconv_bcd_after", 64'(out_bcd_a[0]), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin2bcd_stream.md
BIN2BCD_STREAM -- requirements
Module: bin2bcd_stream

Interface
REQ-001 SHALL have parameter BIN_W, default 12: binary input width, legal range 4..32.
REQ-002 SHALL have parameter DIGITS, default 4: BCD output digits, legal range 1..10.
REQ-003 SHALL have parameter SIGNED_EN, default 0: 1 = treat in_data as two's complement.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  input word present.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port in_data  input  BIN_W  binary value to convert.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port out_bcd  output  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0].
REQ-012 SHALL have port out_neg  output  1  input was negative (SIGNED_EN=1 only, else 0).
REQ-013 SHALL have port out_ovf  output  1  magnitude exceeded 10^DIGITS-1.

Function
REQ-014 SHALL use states IDLE, CONV, DONE; reset state IDLE.
REQ-015 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready).
REQ-016 SHALL, on accept (in_valid and in_ready), latch the magnitude, clear the BCD digits and out_ovf, load bit counter = BIN_W, and enter CONV.
REQ-017 SHALL, with SIGNED_EN=1 and in_data MSB=1, use magnitude = two's-complement negation as a BIN_W-bit unsigned value (most negative maps to 2^(BIN_W-1)) and set out_neg.
REQ-018 SHALL, in each CONV cycle, add 3 to every BCD digit >=5, then shift the combined register left one bit, in the same cycle; exactly one bit per cycle.
REQ-019 SHALL set sticky out_ovf when a 1 is shifted out of the top BCD digit.
REQ-020 SHALL enter DONE after the BIN_W-th shift; out_valid rises exactly BIN_W cycles after the accepting edge.
REQ-021 SHALL, when out_ovf=1, present out_bcd = magnitude mod 10^DIGITS.
REQ-022 SHALL hold out_valid, out_bcd, out_neg and out_ovf stable in DONE until out_ready=1.
REQ-023 SHALL, in DONE with out_ready=1 and in_valid=1, accept the new word on the same edge and go directly to CONV (zero-bubble back-to-back).
REQ-024 SHALL, in DONE with out_ready=1 and in_valid=0, return to IDLE.
REQ-025 SHALL ignore in_valid and in_data while in CONV (in_ready=0).
REQ-026 SHALL keep out_valid=0 in IDLE and CONV; out_bcd may change only in CONV or on accept.

Reset
REQ-027 SHALL, on a clock edge with reset_n=0, force state IDLE, out_valid=0, out_bcd=0, out_neg=0, out_ovf=0 and bit counter 0.
REQ-028 SHALL abort any conversion in progress on reset with no result emitted; in_ready=1 on the first cycle after reset_n returns to 1.

Structure
REQ-029 SHALL place the state encoding and a constant function for the digit count needed for BIN_W in shared package bin2bcd_pkg.
REQ-030 SHALL implement the per-digit add-3 correction in combinational sub-module bcd_digit_adj (4-bit in, 4-bit out), instantiated DIGITS times by generate.
REQ-031 SHALL flag an elaboration error when a parameter is out of range.

Verification
REQ-032 SHALL cover: defaults, in_data=4095, out_ready=1 -> out_bcd=0x4095, out_ovf=0, out_valid exactly 12 cycles after accept.
REQ-033 SHALL cover: SIGNED_EN=1, BIN_W=12, in_data=0x800 -> out_bcd=0x2048, out_neg=1; in_data=0xFFF -> 0x0001, out_neg=1.
REQ-034 SHALL cover: DIGITS=3, in_data=1234 -> out_bcd=0x234, out_ovf=1; in_data=999 -> 0x999, out_ovf=0.
REQ-035 SHALL cover: out_ready=0 for 5 cycles in DONE -> outputs stable; then out_ready=1 with in_valid=1 carrying 7 -> 0x0007 valid 12 cycles later, no idle bubble.
REQ-036 SHALL cover: reset_n=0 for one cycle during the 6th CONV cycle -> out_valid stays 0, all outputs 0, in_ready=1 next cycle.
REQ-037 SHALL cover: in_valid toggling during CONV with values 1..5 -> none accepted; only the first word produces a result.
